// File: rtl/cache_types_pkg.sv
// Shared coherence types: MESI line states, snoop bus opcodes and the
// bus sequencer state encoding.
package cache_types;

   typedef enum logic [1:0] {
      invalid   = 2'b00,
      shared    = 2'b01,
      exclusive = 2'b10,
      modified  = 2'b11
   } mesi_t;

   typedef enum logic [1:0] {
      BUS_RD   = 2'b00,
      BUS_RDX  = 2'b01,
      BUS_UPGR = 2'b10
   } bus_op_t;

   typedef enum logic [2:0] {
      IDLE,
      SNOOP,
      C2C,
      WB,
      MEM,
      DONE
   } snoop_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int IDX_W     = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_CORES-1:0] gnt,
   output logic [IDX_W-1:0]     idx,
   output logic                 valid
);

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         int j;
         j = (int'(ptr) + i) % NUM_CORES;
         if (!valid && req[j]) begin
            valid  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snoop bus sequencer: grants one cache, broadcasts the snoop, gathers the
// responses and drives cache-to-cache, writeback and memory-fetch phases.
module snoop_bus_ctrl
   import cache_types::*;
#(
   parameter int NUM_CORES     = 2,
   parameter int ADDR_WIDTH    = 32,
   parameter int SNOOP_TIMEOUT = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_CORES-1:0]            req,
   input  logic [2*NUM_CORES-1:0]          req_op,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_CORES-1:0]            gnt,
   output logic [NUM_CORES-1:0]            done,
   output logic [1:0]                      fill_state,
   output logic                            snoop_valid,
   output logic [1:0]                      snoop_op,
   output logic [ADDR_WIDTH-1:0]           snoop_addr,
   output logic [$clog2(NUM_CORES)-1:0]    snoop_src,
   input  logic [NUM_CORES-1:0]            snoop_ack,
   input  logic [NUM_CORES-1:0]            snoop_hit,
   input  logic [NUM_CORES-1:0]            snoop_dirty,
   output logic                            c2c_en,
   output logic [$clog2(NUM_CORES)-1:0]    c2c_src,
   output logic                            mem_req,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   input  logic                            mem_resp,
   output logic                            err_timeout
);

   localparam int IDX_W = $clog2(NUM_CORES);
   localparam int CNT_W = $clog2(SNOOP_TIMEOUT);

   snoop_state_t         state;
   bus_op_t              op_q;
   mesi_t                fill_q;
   logic                 wb_pend;
   logic [IDX_W-1:0]     ptr;
   logic [IDX_W-1:0]     arb_idx;
   logic [NUM_CORES-1:0] arb_gnt;
   logic                 arb_valid;
   logic [NUM_CORES-1:0] acked, hit_m, dirty_m;
   logic [CNT_W-1:0]     tmo_cnt;

   logic [NUM_CORES-1:0] ack_new, acked_now, hit_now, dirty_now;
   logic                 all_acked, tmo_hit, any_hit, any_dirty;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CORES-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--)
         if (v[i]) r = IDX_W'(i);
      return r;
   endfunction

   rr_arbiter #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // Responses arriving this cycle count toward the branch decision.
   assign ack_new   = snoop_ack & ~gnt;
   assign acked_now = acked | ack_new;
   assign hit_now   = hit_m | (ack_new & snoop_hit);
   assign dirty_now = dirty_m | (ack_new & snoop_dirty);
   assign all_acked = &(acked_now | gnt);
   assign tmo_hit   = (tmo_cnt == CNT_W'(SNOOP_TIMEOUT - 1));
   assign any_hit   = |(hit_now | dirty_now);
   assign any_dirty = |dirty_now;

   assign snoop_op = op_q;
   assign mem_addr = snoop_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= '0;
         gnt         <= '0;
         done        <= '0;
         fill_state  <= '0;
         snoop_valid <= 1'b0;
         op_q        <= BUS_RD;
         snoop_addr  <= '0;
         snoop_src   <= '0;
         c2c_en      <= 1'b0;
         c2c_src     <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         err_timeout <= 1'b0;
         acked       <= '0;
         hit_m       <= '0;
         dirty_m     <= '0;
         tmo_cnt     <= '0;
         fill_q      <= invalid;
         wb_pend     <= 1'b0;
      end else begin
         done       <= '0;
         fill_state <= '0;
         c2c_en     <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  gnt         <= arb_gnt;
                  snoop_valid <= 1'b1;
                  op_q        <= bus_op_t'(req_op[int'(arb_idx)*2 +: 2]);
                  snoop_addr  <= req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                  snoop_src   <= arb_idx;
                  acked       <= '0;
                  hit_m       <= '0;
                  dirty_m     <= '0;
                  tmo_cnt     <= '0;
                  state       <= SNOOP;
               end
            end
            SNOOP: begin
               acked   <= acked_now;
               hit_m   <= hit_now;
               dirty_m <= dirty_now;
               tmo_cnt <= tmo_cnt + 1'b1;
               if (all_acked || tmo_hit) begin
                  snoop_valid <= 1'b0;
                  if (!all_acked) err_timeout <= 1'b1;
                  if (op_q == BUS_UPGR) begin
                     done       <= gnt;
                     fill_state <= modified;
                     state      <= DONE;
                  end else begin
                     fill_q <= (op_q == BUS_RD) ? (any_hit ? shared : exclusive) : modified;
                     if (any_hit) begin
                        c2c_en  <= 1'b1;
                        c2c_src <= any_dirty ? lowest_idx(dirty_now) : lowest_idx(hit_now);
                        wb_pend <= any_dirty && (op_q == BUS_RD);
                        state   <= C2C;
                     end else begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state   <= MEM;
                     end
                  end
               end
            end
            C2C: begin
               if (wb_pend) begin
                  mem_req <= 1'b1;
                  mem_we  <= 1'b1;
                  state   <= WB;
               end else begin
                  done       <= gnt;
                  fill_state <= fill_q;
                  state      <= DONE;
               end
            end
            WB, MEM: begin
               if (mem_resp) begin
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  done       <= gnt;
                  fill_state <= fill_q;
                  state      <= DONE;
               end
            end
            DONE: begin
               gnt   <= '0;
               ptr   <= (snoop_src == IDX_W'(NUM_CORES - 1)) ? '0 : snoop_src + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl: directed scenarios, random batches of
// contending requests, snoop timeouts and an asynchronous reset mid-fetch.
module tb_snoop_bus_ctrl;
   import cache_types::*;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int TMO = 16;
   localparam int IW  = $clog2(N);

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [2*N-1:0]  req_op;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    gnt, done;
   logic [1:0]      fill_state;
   logic            snoop_valid;
   logic [1:0]      snoop_op;
   logic [AW-1:0]   snoop_addr;
   logic [IW-1:0]   snoop_src;
   logic [N-1:0]    snoop_ack, snoop_hit, snoop_dirty;
   logic            c2c_en;
   logic [IW-1:0]   c2c_src;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic            mem_resp;
   logic            err_timeout;

   snoop_bus_ctrl #(.NUM_CORES(N), .ADDR_WIDTH(AW), .SNOOP_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
      .gnt(gnt), .done(done), .fill_state(fill_state), .snoop_valid(snoop_valid),
      .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
      .snoop_ack(snoop_ack), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
      .c2c_en(c2c_en), .c2c_src(c2c_src), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_resp(mem_resp), .err_timeout(err_timeout)
   );

   // One bus transaction as the requester and the snoopers will play it.
   typedef struct {
      int            core;
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [N-1:0]  hit, dirty, noack;
      bit            gack;
      int            a;
      int            m;
   } txn_t;

   typedef struct {
      int            core;
      logic [1:0]    fill;
      bit            c2c;
      int            src;
      bit            mem;
      bit            we;
      logic [AW-1:0] addr;
      bit            err;
      int            lat;
   } exp_t;

   txn_t plan_q[$];
   exp_t exp_q[$];
   int   mem_q[$];
   txn_t cur[N];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int mptr       = 0;
   bit model_err  = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic finish_sim;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   endtask

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [N-1:0] bit_of(input int c);
      return N'(1) << c;
   endfunction

   // Reference outcome of one transaction, straight from the bus rules.
   task automatic model(input txn_t t);
      logic [N-1:0] others, ackd, h, d;
      bit           tmo;
      int           b;
      exp_t         e;
      others = ~bit_of(t.core);
      ackd   = others & ~t.noack;
      h      = t.hit & ackd;
      d      = t.dirty & t.hit & ackd;
      tmo    = (others & t.noack) != 0;
      b      = tmo ? TMO - 1 : t.a;
      model_err = model_err | tmo;
      e.core = t.core; e.addr = t.addr; e.err = model_err;
      e.c2c = 1'b0; e.src = 0; e.mem = 1'b0; e.we = 1'b0;
      if (t.op == BUS_UPGR) begin
         e.fill = modified; e.lat = b + 1;
      end else if (d != 0) begin
         e.c2c = 1'b1; e.src = lowest(d);
         if (t.op == BUS_RD) begin
            e.fill = shared; e.mem = 1'b1; e.we = 1'b1; e.lat = b + 3 + t.m;
         end else begin
            e.fill = modified; e.lat = b + 2;
         end
      end else if (h != 0) begin
         e.c2c = 1'b1; e.src = lowest(h);
         e.fill = (t.op == BUS_RD) ? shared : modified;
         e.lat = b + 2;
      end else begin
         e.mem = 1'b1;
         e.fill = (t.op == BUS_RD) ? exclusive : modified;
         e.lat = b + 2 + t.m;
      end
      if (e.mem) mem_q.push_back(t.m);
      plan_q.push_back(t);
      exp_q.push_back(e);
   endtask

   task automatic run_batch(input logic [N-1:0] set);
      logic [N-1:0] rem;
      int           j, bound;
      @(negedge clk);
      for (int i = 0; i < N; i++)
         if (set[i]) begin
            req_op[2*i +: 2]    = cur[i].op;
            req_addr[AW*i +: AW] = cur[i].addr;
         end
      rem = set;
      while (rem != 0) begin
         j = mptr;
         while (!rem[j]) j = (j + 1) % N;
         model(cur[j]);
         rem[j] = 1'b0;
         mptr = (j + 1) % N;
      end
      req = set;
      bound = 0;
      while (req != 0 && bound < 300) begin
         @(negedge clk);
         req = req & ~done;
         bound++;
      end
      if (req != 0) begin
         check("served_in_time", 64'(req), 64'(0));
         finish_sim();
      end
   endtask

   task automatic single(input int c, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [N-1:0] hit, input logic [N-1:0] dirty,
                         input logic [N-1:0] noack, input int a, input int m);
      cur[c] = '{core:c, op:op, addr:addr, hit:hit, dirty:dirty, noack:noack, gack:1'b1, a:a, m:m};
      run_batch(bit_of(c));
   endtask

   task automatic rand_txn(input int c, input bit allow_tmo);
      cur[c].core  = c;
      cur[c].op    = 2'($urandom_range(0, 2));
      cur[c].addr  = $urandom & ~32'h3F;
      cur[c].hit   = N'($urandom);
      cur[c].dirty = cur[c].hit & N'($urandom) & N'($urandom);
      cur[c].noack = (allow_tmo && $urandom_range(0, 7) == 0) ? bit_of($urandom_range(0, N-1)) : '0;
      cur[c].gack  = 1'($urandom_range(0, 1));
      cur[c].a     = $urandom_range(0, 4);
      cur[c].m     = $urandom_range(0, 5);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_gnt"},         64'(gnt), 64'(0));
      check({tag, "_done"},        64'(done), 64'(0));
      check({tag, "_fill"},        64'(fill_state), 64'(0));
      check({tag, "_snoop_valid"}, 64'(snoop_valid), 64'(0));
      check({tag, "_snoop_addr"},  64'(snoop_addr), 64'(0));
      check({tag, "_c2c_en"},      64'(c2c_en), 64'(0));
      check({tag, "_mem_req"},     64'(mem_req), 64'(0));
      check({tag, "_mem_we"},      64'(mem_we), 64'(0));
      check({tag, "_mem_addr"},    64'(mem_addr), 64'(0));
      check({tag, "_err"},         64'(err_timeout), 64'(0));
   endtask

   // Snoopers: respond per plan, with junk on lines that carry no ack.
   initial begin
      txn_t         p;
      logic [N-1:0] ackd;
      int           bound;
      snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0;
      forever begin
         @(negedge clk);
         if (rst && snoop_valid) begin
            if (plan_q.size() == 0) begin
               check("snoop_without_plan", 64'(snoop_valid), 64'(0));
            end else begin
               p = plan_q.pop_front();
               check("snoop_src",  64'(snoop_src), 64'(p.core));
               check("snoop_op",   64'(snoop_op), 64'(p.op));
               check("snoop_addr", 64'(snoop_addr), 64'(p.addr));
               repeat (p.a) @(negedge clk);
               ackd        = ~bit_of(p.core) & ~p.noack;
               snoop_ack   = ackd | (p.gack ? bit_of(p.core) : '0);
               snoop_hit   = (p.hit & ackd) | (~ackd & N'($urandom));
               snoop_dirty = (p.dirty & ackd) | (~ackd & N'($urandom));
               @(negedge clk);
               snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0;
               bound = 0;
               while (snoop_valid && bound < 40) begin
                  @(negedge clk);
                  bound++;
               end
            end
         end
      end
   end

   // Memory adaptor: one-cycle response after the planned delay.
   initial begin
      int m;
      mem_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && mem_req) begin
            m = (mem_q.size() != 0) ? mem_q.pop_front() : 0;
            repeat (m) @(negedge clk);
            mem_resp = 1'b1;
            @(negedge clk);
            mem_resp = 1'b0;
         end
      end
   end

   // Monitor: observe each granted transaction and score it at done.
   int            g_cyc, c2c_cnt, c2c_s;
   bit            in_txn = 1'b0, mem_seen, we_s;
   logic [AW-1:0] addr_s;
   exp_t          e;

   always @(negedge clk) begin
      if (!rst) begin
         in_txn = 1'b0;
      end else begin
         if (gnt != 0 && !in_txn) begin
            in_txn = 1'b1; g_cyc = cyc; c2c_cnt = 0; c2c_s = 0;
            mem_seen = 1'b0; we_s = 1'b0; addr_s = '0;
         end
         if (c2c_en) begin
            c2c_cnt++;
            c2c_s = int'(c2c_src);
         end
         if (mem_req) begin
            mem_seen = 1'b1; we_s = mem_we; addr_s = mem_addr;
         end
         if (c2c_en || mem_req)
            check("c2c_mem_overlap", 64'(c2c_en & mem_req), 64'(0));
         if (done != 0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'(done), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("done_vec",   64'(done), 64'(bit_of(e.core)));
               check("gnt_held",   64'(gnt), 64'(bit_of(e.core)));
               check("fill_state", 64'(fill_state), 64'(e.fill));
               check("c2c_count",  64'(c2c_cnt), 64'(e.c2c ? 1 : 0));
               if (e.c2c) check("c2c_src", 64'(c2c_s), 64'(e.src));
               check("mem_seen",   64'(mem_seen), 64'(e.mem));
               if (e.mem) begin
                  check("mem_we",   64'(we_s), 64'(e.we));
                  check("mem_addr", 64'(addr_s), 64'(e.addr));
               end
               check("err_timeout", 64'(err_timeout), 64'(e.err));
               check("latency",     64'(cyc - g_cyc), 64'(e.lat));
            end
            in_txn = 1'b0;
         end
      end
   end

   initial begin
      int b;
      rst = 1'b0; req = '0; req_op = '0; req_addr = '0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b1;

      single(0, BUS_RD,   32'h1000, 4'b0000, 4'b0000, 4'b0000, 0, 2);
      single(0, BUS_RD,   32'h2040, 4'b0010, 4'b0010, 4'b0000, 0, 1);
      single(1, BUS_UPGR, 32'h3000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
      single(2, BUS_RDX,  32'h4000, 4'b1010, 4'b0000, 4'b0000, 2, 0);
      single(3, BUS_RD,   32'h4400, 4'b0101, 4'b0000, 4'b0000, 1, 0);
      cur[0] = '{core:0, op:BUS_RD, addr:32'h5000, hit:'0, dirty:'0, noack:'0, gack:1'b0, a:0, m:1};
      cur[1] = '{core:1, op:BUS_RD, addr:32'h5100, hit:'0, dirty:'0, noack:'0, gack:1'b0, a:1, m:0};
      run_batch(4'b0011);
      single(2, BUS_RD,   32'h6000, 4'b0010, 4'b0000, 4'b0010, 1, 1);
      single(3, BUS_RDX,  32'h6100, 4'b0111, 4'b0110, 4'b0000, 0, 0);

      for (int k = 0; k < 60; k++) begin
         logic [N-1:0] set;
         set = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++)
            if (set[i]) rand_txn(i, k >= 20);
         run_batch(set);
      end

      single(1, BUS_UPGR, 32'h7000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
      cur[0] = '{core:0, op:BUS_RD, addr:32'h8000, hit:'0, dirty:'0, noack:'0, gack:1'b0, a:0, m:30};
      @(negedge clk);
      req_op[1:0] = BUS_RD;
      req_addr[AW-1:0] = 32'h8000;
      model(cur[0]);
      req = bit_of(0);
      b = 0;
      while (!mem_req && b < 20) begin
         @(negedge clk);
         b++;
      end
      check("mem_req_before_reset", 64'(mem_req), 64'(1));
      rst = 1'b0;
      req = '0;
      #1;
      check_idle_outputs("midreset");
      plan_q.delete(); exp_q.delete(); mem_q.delete();
      mptr = 0; model_err = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cur[1] = '{core:1, op:BUS_UPGR, addr:32'h9000, hit:'0, dirty:'0, noack:'0, gack:1'b0, a:0, m:0};
      cur[3] = '{core:3, op:BUS_UPGR, addr:32'h9300, hit:'0, dirty:'0, noack:'0, gack:1'b0, a:0, m:0};
      run_batch(4'b1010);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      finish_sim();
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/snoop_bus_ctrl.md
# snoop_bus_ctrl

Sequencer and arbiter for the shared coherence (snoop) bus between the per-core L1 caches and their MESI controllers. It grants one requesting cache at a time using round-robin, then broadcasts the BusRd/BusRdX/BusUpgr snoop and collects every other cache's snoop response. Depending on the outcome it runs a cache-to-cache (FlushOpt) transfer, a dirty writeback, and/or a memory fetch through the adaptor. It ends each transaction by returning the fill MESI state to the requester.

## Interface
- NUM_CORES, 2, number of cache requesters (2..4)
- ADDR_WIDTH, 32, line address width
- SNOOP_TIMEOUT, 16, max cycles waiting for snoop acks (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req  in  NUM_CORES  per-cache bus request; held until done
- req_op  in  NUM_CORES×2  bus_op_t per requester
- req_addr  in  NUM_CORES×ADDR_WIDTH  line address per requester
- gnt  out  NUM_CORES  one-hot grant, held through transaction
- done  out  NUM_CORES  one-cycle completion pulse to grantee
- fill_state  out  2  mesi_t for grantee's line, valid with done
- snoop_valid  out  1  snoop broadcast active
- snoop_op  out  2  granted bus_op_t
- snoop_addr  out  ADDR_WIDTH  granted address
- snoop_src  out  $clog2(NUM_CORES)  grantee index
- snoop_ack  in  NUM_CORES  snooper response valid
- snoop_hit  in  NUM_CORES  snooper holds line (S/E/M), qualified by ack
- snoop_dirty  in  NUM_CORES  snooper holds line in M, qualified by ack
- c2c_en  out  1  FlushOpt: supplier drives line to grantee this cycle
- c2c_src  out  $clog2(NUM_CORES)  supplier index
- mem_req  out  1  adaptor request, held until mem_resp
- mem_we  out  1  1 = writeback, 0 = line read
- mem_addr  out  ADDR_WIDTH  adaptor address (= snoop_addr)
- mem_resp  in  1  adaptor one-cycle completion
- err_timeout  out  1  sticky, set on snoop timeout, cleared only by reset

## Operation
- States: IDLE, SNOOP, C2C, WB, MEM, DONE.
- IDLE: if any req, rr_arbiter picks the winner starting at ptr. gnt, snoop_* and the latched op/addr are registered, and the FSM enters SNOOP.
- SNOOP:
  - snoop_valid=1.
  - Acks from non-grantees accumulate into a pending mask; hit/dirty latch with their ack; the grantee's ack is ignored.
  - When all non-grantee acks are collected (including acks arriving in the current cycle), the FSM branches:
    - BUS_UPGR → DONE, fill = modified.
    - Any dirty hit → C2C (supplier = dirty core); BUS_RD then goes to WB, BUS_RDX to DONE.
    - Any clean hit → C2C, supplier = lowest-index hitter.
    - No hit → MEM.
- C2C: c2c_en=1 for exactly 1 cycle.
- WB: mem_req=1, mem_we=1 until mem_resp, then DONE.
- MEM: mem_req=1, mem_we=0 until mem_resp, then DONE.
- DONE: done[grantee]=1 and fill_state are driven for 1 cycle. ptr ← grantee+1 (mod NUM_CORES), gnt clears, FSM returns to IDLE.
- fill_state:
  - BUS_RD: shared if any hit, else exclusive.
  - BUS_RDX and BUS_UPGR: modified.
- Snoop timeout: the counter reaches SNOOP_TIMEOUT-1 in SNOOP. Missing acks count as miss, err_timeout is set, and branching proceeds on the acks collected so far.

## Timing
- Reset: all outputs 0, ptr=0, FSM in IDLE, pending/hit/dirty masks and timeout counter cleared. An in-flight transaction is dropped. Snoopers must tolerate loss of snoop_valid.
- Grant latency: req at cycle 0 in IDLE → gnt and snoop_valid at cycle 1.
- Minimum latencies:
  - Upgrade with acks at cycle 1: done at cycle 2.
  - Clean hit: c2c_en at 2, done at 3.
  - Miss: mem_req from 2; mem_resp at cycle k gives done at k+1.
- Requester handshake: req, req_op and req_addr stay stable until done. req must be low in the cycle after done, otherwise it is treated as a new request.
- Simultaneous requests: the lowest index at or after ptr wins; others wait with gnt=0 and no timeout.
- mem_resp outside WB/MEM is ignored. c2c_en and mem_req are never high in the same cycle.
- Multiple dirty acks indicate a coherence violation: the lowest index is used and err_timeout is not affected.

## Structure
- Package cache_types holds:
  - mesi_t: invalid=2'b00, shared=2'b01, exclusive=2'b10, modified=2'b11.
  - bus_op_t: BUS_RD=2'b00, BUS_RDX=2'b01, BUS_UPGR=2'b10.
  - snoop_state_t FSM enum.
- Sub-module rr_arbiter (req, ptr → one-hot gnt, index) is purely combinational; ptr is owned by snoop_bus_ctrl.

## Test plan
- BUS_RD miss: core0 req, addr 0x1000, acks with hit=0 at cycle 1 → mem_req 0x1000 we=0 from cycle 2; mem_resp at 4 → done[0] at 5, fill=exclusive.
- BUS_RD dirty hit: core1 ack hit=1 dirty=1 → c2c_en, c2c_src=1 at cycle 2; WB mem_we=1; mem_resp → done[0], fill=shared.
- BUS_UPGR: core1 req, acks at cycle 1 → done[1] at cycle 2, fill=modified, no mem_req, no c2c_en.
- Contention: core0 and core1 req at cycle 0 with ptr=0 → core0 served first, then core1. A core0 re-request does not win the next arbitration.
- Timeout: core1 never acks with SNOOP_TIMEOUT=16 → branch after 16 SNOOP cycles as a miss, err_timeout=1 and stays set.
- Reset mid-MEM: rst low while mem_req=1 → all outputs 0 immediately; after release, IDLE with ptr=0.
